latch_write_ctrl: RTL and testbench
===================================

Name: latch_write_ctrl

Overview:
- Initiator (writer) side for a bank of gated level-sensitive D latches: accepts a data word over a valid/ready handshake and drives the latch D inputs and the gate enable G.
- Sequence per write: setup window, gate pulse, hold window.
- Guarantees D is stable around the whole G pulse, so downstream latch banks capture cleanly.
- Sits between synchronous control logic and latch-based storage.

Parameters:
- WIDTH, 4, data word width driven onto latch D inputs.
- SETUP_CYC, 1, clock cycles D is stable before G rises (min 1).
- PULSE_CYC, 2, clock cycles G is held high (min 1).
- HOLD_CYC, 1, clock cycles D is held after G falls (min 1).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  write request.
- wr_ready  output  1  controller idle; a request is accepted this cycle if wr_valid=1.
- wr_data  input  WIDTH  word to write, sampled on acceptance.
- lat_d  output  WIDTH  registered drive to latch D inputs.
- lat_g  output  1  registered latch gate enable.
- busy  output  1  high from the cycle after acceptance through the DONE state.
- done  output  1  one-cycle pulse when a write sequence completes.
- lat_q  input  WIDTH  latch Q readback (present only with LATCH_READBACK_EN).
- rb_err  output  1  readback mismatch flag (present only with LATCH_READBACK_EN).

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state changes occur on the rising edge of clk.
- Reset values: state=IDLE, lat_d=0, lat_g=0, busy=0, done=0, rb_err=0, cycle counter=0. wr_ready=1 from the first cycle after reset.
- wr_ready=1 only in IDLE, and is decoded from state. Acceptance means wr_valid & wr_ready at a clock edge.
- On acceptance, wr_data is registered into lat_d and the FSM enters SETUP. wr_data is ignored at all other times.

State machine:
- IDLE: lat_g=0; lat_d keeps its last value, so latch inputs do not toggle. Goes to SETUP on acceptance.
- SETUP: lasts SETUP_CYC cycles with lat_g=0, then goes to GATE.
- GATE: lasts PULSE_CYC cycles with lat_g=1, then goes to HOLD.
- HOLD: lasts HOLD_CYC cycles with lat_g=0, then goes to DONE.
- DONE: lasts 1 cycle with done=1 and wr_ready=0, then goes to IDLE.
- lat_d is constant from SETUP entry through DONE.

Timing and counter:
- Latency: accept edge to done pulse = SETUP_CYC+PULSE_CYC+HOLD_CYC cycles. Next accept is possible one cycle later.
- A single down-counter is loaded with (N-1) on entry to each timed state, and the state exits when the count reaches 0.
- Counter width = $clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1).

Boundary conditions:
- wr_valid held high continuously: back-to-back writes, with exactly one IDLE cycle between sequences.
- wr_valid deasserted mid-sequence: no effect.
- rst mid-sequence, including during GATE: lat_g is 0 at the next edge, lat_d is cleared to 0, and no done pulse is produced.
- rst and wr_valid asserted together: rst wins and the request is not accepted.
- busy=0 in IDLE, 1 in SETUP, GATE, HOLD and DONE.

Optional Feature:
- Macro LATCH_READBACK_EN.
- When defined: the lat_q input and rb_err output exist. In the DONE state, lat_q is compared with lat_d. rb_err is registered, updates at the DONE→IDLE edge, holds until the next acceptance (cleared at acceptance), and resets to 0.
- When undefined: the ports are absent and no compare logic is built. Sequencing is identical either way.

Decomposition:
- Shared package/header latch_ctrl_pkg holds:
  - state encoding constants ST_IDLE, ST_SETUP, ST_GATE, ST_HOLD, ST_DONE (3-bit);
  - a max-of-three constant function used for the counter width.
- One natural sub-module: cyc_timer. It is a loadable down-counter with a load input, a load value, and a zero flag, and is shared by all three timed states.

Test Plan (WIDTH=4, SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=1 unless noted):
- Reset, then idle → lat_g=0, lat_d=0, wr_ready=1, busy=0, done=0.
- Single write of wr_data=4'hA at edge T → lat_d=4'hA from T. lat_g=1 exactly on edges T+2..T+4 (3 cycles). done pulses at T+6. wr_ready=1 again at T+7.
- wr_valid held high with data 4'h3 then 4'hC → two complete sequences separated by exactly one IDLE cycle. lat_d changes only at the second acceptance.
- rst asserted during the 2nd GATE cycle → lat_g=0 and lat_d=0 at the next edge, no done pulse, wr_ready=1 afterwards.
- With LATCH_READBACK_EN, instantiating a behavioural latch model (D, G in; Q out) → write 4'h5 gives rb_err=0. With lat_q forced to 4'h4, the same write gives rb_err=1, which clears on the next acceptance.
- Parameters SETUP_CYC=PULSE_CYC=HOLD_CYC=1 → G pulse of exactly 1 cycle, done 3 cycles after acceptance.

Source files
------------

// File: rtl/latch_ctrl_pkg.sv
// Shared state encoding and constant helpers for the latch write controller.
package latch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_GATE  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/latch_write_ctrl_cyc_timer.sv
// Loadable down-counter shared by the setup, gate and hold windows.
module cyc_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/latch_write_ctrl.sv
// Writer for a gated D-latch bank: setup window, gate pulse, hold window.
// Optional latch readback compare is enabled by defining LATCH_READBACK_EN.
module latch_write_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_g,
  output logic             busy,
  output logic             done
`ifdef LATCH_READBACK_EN
  ,
  input  logic [WIDTH-1:0] lat_q,
  output logic             rb_err
`endif
);

  localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  state_t        state, next_state;
  logic          accept;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_zero;

  cyc_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign wr_ready = (state == ST_IDLE);
  assign accept   = wr_valid & wr_ready;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  // The timer is reloaded on every entry into a timed state.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    unique case (state)
      ST_IDLE:
        if (wr_valid) begin
          next_state = ST_SETUP;
          tmr_load   = 1'b1;
          tmr_val    = SETUP_LD;
        end
      ST_SETUP:
        if (tmr_zero) begin
          next_state = ST_GATE;
          tmr_load   = 1'b1;
          tmr_val    = PULSE_LD;
        end
      ST_GATE:
        if (tmr_zero) begin
          next_state = ST_HOLD;
          tmr_load   = 1'b1;
          tmr_val    = HOLD_LD;
        end
      ST_HOLD:
        if (tmr_zero) next_state = ST_DONE;
      ST_DONE:
        next_state = ST_IDLE;
      default:
        next_state = ST_IDLE;
    endcase
  end

  // Gate is registered from next state so it is glitch-free at the latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      lat_g <= 1'b0;
      lat_d <= '0;
    end else begin
      state <= next_state;
      lat_g <= (next_state == ST_GATE);
      if (accept)
        lat_d <= wr_data;
    end
  end

`ifdef LATCH_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst)
      rb_err <= 1'b0;
    else if (accept)
      rb_err <= 1'b0;
    else if (state == ST_DONE)
      rb_err <= (lat_q != lat_d);
  end
`endif

endmodule

// File: tb/tb_latch_write_ctrl.sv
// Directed self-checking bench for latch_write_ctrl (main and minimum-timing configs).
module tb_latch_write_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, wr_valid1;
  logic [3:0] wr_data, wr_data1;
  logic       wr_ready, wr_ready1;
  logic [3:0] lat_d, lat_d1;
  logic       lat_g, lat_g1;
  logic       busy, busy1;
  logic       done, done1;

  int num_compared   = 0;
  int num_mismatched = 0;

`ifdef LATCH_READBACK_EN
  logic [3:0] latch_q;
  logic [3:0] lat_q;
  logic       force_q;
  logic       rb_err, rb_err1;

  always_latch begin
    if (lat_g) latch_q = lat_d;
  end
  assign lat_q = force_q ? 4'h4 : latch_q;
`endif

  always #5 clk = ~clk;

  latch_write_ctrl #(.WIDTH(4), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(1)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .lat_d(lat_d), .lat_g(lat_g), .busy(busy), .done(done)
`ifdef LATCH_READBACK_EN
    , .lat_q(lat_q), .rb_err(rb_err)
`endif
  );

  latch_write_ctrl #(.WIDTH(4), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid1), .wr_ready(wr_ready1), .wr_data(wr_data1),
    .lat_d(lat_d1), .lat_g(lat_g1), .busy(busy1), .done(done1)
`ifdef LATCH_READBACK_EN
    , .lat_q(lat_d1), .rb_err(rb_err1)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] data);
    wr_valid = valid;
    wr_data  = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wr_valid1 = 1'b0;
    wr_data1  = 4'h0;
`ifdef LATCH_READBACK_EN
    force_q = 1'b0;
`endif
    applyStimulus(1'b0, 4'h0);
    tick();
    tick();
    checkOutput("rst_lat_g", 32'(lat_g), 32'd0);
    checkOutput("rst_lat_d", 32'(lat_d), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
    rst = 1'b0;
    tick();
    checkOutput("idle_wr_ready", 32'(wr_ready), 32'd1);

    // Single write of 0xA; valid dropped right after acceptance.
    applyStimulus(1'b1, 4'hA);
    tick();
    checkOutput("wrA_lat_d", 32'(lat_d), 32'hA);
    checkOutput("wrA_busy", 32'(busy), 32'd1);
    checkOutput("wrA_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("wrA_lat_g0", 32'(lat_g), 32'd0);
    applyStimulus(1'b0, 4'hF);
    for (int k = 1; k <= 7; k++) begin
      tick();
      checkOutput($sformatf("wrA_lat_g_T%0d", k), 32'(lat_g), 32'((k >= 2) && (k <= 4)));
      checkOutput($sformatf("wrA_done_T%0d", k), 32'(done), 32'(k == 6));
      checkOutput($sformatf("wrA_ready_T%0d", k), 32'(wr_ready), 32'(k == 7));
      checkOutput($sformatf("wrA_lat_d_T%0d", k), 32'(lat_d), 32'hA);
    end

    // Back-to-back writes with valid held high.
    applyStimulus(1'b1, 4'h3);
    tick();
    checkOutput("b2b_lat_d_first", 32'(lat_d), 32'h3);
    applyStimulus(1'b1, 4'hC);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput($sformatf("b2b_lat_d_T%0d", k), 32'(lat_d), (k < 8) ? 32'h3 : 32'hC);
      checkOutput($sformatf("b2b_ready_T%0d", k), 32'(wr_ready), 32'(k == 7));
      checkOutput($sformatf("b2b_busy_T%0d", k), 32'(busy), 32'(k != 7));
      checkOutput($sformatf("b2b_done_T%0d", k), 32'(done), 32'(k == 6));
    end
    applyStimulus(1'b0, 4'h0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      checkOutput($sformatf("b2b2_done_T%0d", k), 32'(done), 32'(k == 6));
      checkOutput($sformatf("b2b2_lat_g_T%0d", k), 32'(lat_g), 32'((k >= 2) && (k <= 4)));
      checkOutput($sformatf("b2b2_lat_d_T%0d", k), 32'(lat_d), 32'hC);
    end

    // Reset during the second gate cycle.
    applyStimulus(1'b1, 4'h9);
    tick();
    applyStimulus(1'b0, 4'h0);
    tick();
    tick();
    checkOutput("rstg_gate1", 32'(lat_g), 32'd1);
    tick();
    checkOutput("rstg_gate2", 32'(lat_g), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("rstg_lat_g", 32'(lat_g), 32'd0);
    checkOutput("rstg_lat_d", 32'(lat_d), 32'd0);
    checkOutput("rstg_busy", 32'(busy), 32'd0);
    checkOutput("rstg_ready", 32'(wr_ready), 32'd1);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("rstg_nodone_%0d", k), 32'(done), 32'd0);
      checkOutput($sformatf("rstg_ready_%0d", k), 32'(wr_ready), 32'd1);
    end

    // Reset and valid together: reset wins.
    rst = 1'b1;
    applyStimulus(1'b1, 4'h7);
    tick();
    checkOutput("rstv_busy", 32'(busy), 32'd0);
    checkOutput("rstv_lat_d", 32'(lat_d), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 4'h0);
    tick();
    checkOutput("rstv_busy_after", 32'(busy), 32'd0);
    checkOutput("rstv_lat_d_after", 32'(lat_d), 32'd0);

    // Minimum timing: one cycle each.
    wr_valid1 = 1'b1;
    wr_data1  = 4'h6;
    tick();
    checkOutput("min_lat_d", 32'(lat_d1), 32'h6);
    checkOutput("min_busy", 32'(busy1), 32'd1);
    wr_valid1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("min_lat_g_T%0d", k), 32'(lat_g1), 32'(k == 1));
      checkOutput($sformatf("min_done_T%0d", k), 32'(done1), 32'(k == 3));
      checkOutput($sformatf("min_ready_T%0d", k), 32'(wr_ready1), 32'(k == 4));
    end

`ifdef LATCH_READBACK_EN
    // Readback against the behavioural latch, then with a stuck value.
    applyStimulus(1'b1, 4'h5);
    tick();
    applyStimulus(1'b0, 4'h0);
    for (int k = 1; k <= 7; k++) tick();
    checkOutput("rb_ok", 32'(rb_err), 32'd0);
    force_q = 1'b1;
    applyStimulus(1'b1, 4'h5);
    tick();
    applyStimulus(1'b0, 4'h0);
    for (int k = 1; k <= 7; k++) tick();
    checkOutput("rb_err_set", 32'(rb_err), 32'd1);
    tick();
    checkOutput("rb_err_hold", 32'(rb_err), 32'd1);
    force_q = 1'b0;
    applyStimulus(1'b1, 4'h5);
    tick();
    checkOutput("rb_err_clr", 32'(rb_err), 32'd0);
    applyStimulus(1'b0, 4'h0);
    for (int k = 1; k <= 7; k++) tick();
    checkOutput("rb_ok2", 32'(rb_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
